// File: rtl/addr_gen.sv
// Address generator: fetches the 16-bit reset vector from FFFC/FFFD, then
// drives the address bus from PC, MAR or the previous cycle's address.
//
// state | meaning
// RV_LO | address FFFC on the bus, capture vector low byte into PC[7:0]
// RV_HI | address FFFD on the bus, capture vector high byte into PC[15:8]
// RUN   | normal operation, address from PC / MAR / previous address
module addr_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [7:0]  db,
   input  logic        adr,
   input  logic        prv,
   input  logic        inc,
   input  logic        lpc,
   input  logic        mlo,
   input  logic        mhi,
   input  logic        minc,
   input  logic        lco,
   output logic [15:0] a,
   output logic [15:0] pc,
   output logic [15:0] mar,
   output logic        vld,
   output logic        pgx
);

   typedef enum logic [1:0] {
      RV_LO = 2'd0,
      RV_HI = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] ap;
   logic        run;

   assign run = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RV_LO;
      end else if (rdy) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RV_LO:   state_nxt = RV_HI;
         RV_HI:   state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = RV_LO;
      endcase
   end

   // Bus select is purely from registers and the mux controls; DB never reaches A.
   always_comb begin
      a   = 16'hFFFC;
      vld = 1'b0;
      case (state)
         RV_LO: a = 16'hFFFC;
         RV_HI: a = 16'hFFFD;
         RUN: begin
            vld = 1'b1;
            if (prv)      a = ap;
            else if (adr) a = mar;
            else          a = pc;
         end
         default: a = 16'hFFFC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ap <= 16'h0000;
      end else if (rdy) begin
         ap <= a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= 16'h0000;
      end else if (rdy) begin
         case (state)
            RV_LO: pc[7:0]  <= db;
            RV_HI: pc[15:8] <= db;
            RUN: begin
               if (lpc)      pc <= mar;
               else if (inc) pc <= pc + 16'd1;
            end
            default: pc <= pc;
         endcase
      end
   end

   // Low byte increments wrap within the page; the carry is applied separately via lco.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mar <= 16'h0000;
      end else if (rdy && run) begin
         if (mlo)       mar[7:0] <= db;
         else if (minc) mar[7:0] <= mar[7:0] + 8'd1;
         if (mhi)       mar[15:8] <= db;
         else if (lco)  mar[15:8] <= mar[15:8] + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pgx <= 1'b0;
      end else if (rdy) begin
         pgx <= run && lco && !mhi;
      end
   end

endmodule
